// File: rtl/trap_controller_if.sv
// trap_controller_if: execute, CSR and fetch-side signals of the trap controller
interface trap_controller_if;
   logic        i_ExcValid;
   logic [3:0]  i_ExcCause;
   logic [31:0] i_ExcPc;
   logic        i_Mret;
   logic [31:0] i_NextPc;
   logic [2:0]  i_IrqPending;
   logic [2:0]  i_IrqEnable;
   logic [31:0] i_Mepc;
   logic        i_FlushAck;
   logic        o_FlushReq;
   logic        o_Stall;
   logic        o_ExceptionRaised;
   logic        o_Interrupt;
   logic [3:0]  o_ExceptionCause;
   logic [31:0] o_ExceptionInstructionPointer;
   logic        o_RedirectValid;
   logic [31:0] o_RedirectPc;
   logic        o_Mie;
   logic        o_Mpie;
   modport slave (
      input  i_ExcValid, i_ExcCause, i_ExcPc, i_Mret, i_NextPc, i_IrqPending, i_IrqEnable, i_Mepc, i_FlushAck,
      output o_FlushReq, o_Stall, o_ExceptionRaised, o_Interrupt, o_ExceptionCause, o_ExceptionInstructionPointer,
             o_RedirectValid, o_RedirectPc, o_Mie, o_Mpie
   );
   modport master (
      output i_ExcValid, i_ExcCause, i_ExcPc, i_Mret, i_NextPc, i_IrqPending, i_IrqEnable, i_Mepc, i_FlushAck,
      input  o_FlushReq, o_Stall, o_ExceptionRaised, o_Interrupt, o_ExceptionCause, o_ExceptionInstructionPointer,
             o_RedirectValid, o_RedirectPc, o_Mie, o_Mpie
   );
endinterface

// File: rtl/trap_controller.sv
// trap_controller: arbitrates exceptions, machine interrupts and MRET, sequences flush, commit and fetch redirect
module trap_controller #(
   parameter logic [31:0] MTVEC_BASE = 32'h0000_0100,
   parameter bit          VECTORED   = 1'b0
) (
   input logic             i_Clock,
   input logic             i_Reset_n,
   trap_controller_if.slave bus
);
   typedef enum logic [1:0] {IDLE, FLUSH, COMMIT} state_t;
   typedef enum logic [1:0] {EXC, IRQ, RET} kind_t;
   localparam logic [31:0] BASE = {MTVEC_BASE[31:2], 2'b00};
   state_t      state_q;
   kind_t       kind_q, kind_d;
   logic [3:0]  cause_q, cause_d, ecause_q;
   logic [31:0] pc_q, pc_d, epc_q, redir_q, target;
   logic [2:0]  irq;
   logic        irq_req, req;
   logic        flush_q, stall_q, raised_q, intr_q, redir_valid_q, mie_q, mpie_q;
   always_comb begin
      irq     = bus.i_IrqPending & bus.i_IrqEnable;
      irq_req = mie_q & |irq;
      req     = bus.i_ExcValid | irq_req | bus.i_Mret;
      kind_d  = bus.i_ExcValid ? EXC : irq_req ? IRQ : RET;
      cause_d = bus.i_ExcValid ? bus.i_ExcCause : irq[2] ? 4'd11 : irq[1] ? 4'd3 : 4'd7;
      pc_d    = bus.i_ExcValid ? bus.i_ExcPc : bus.i_NextPc;
      target  = (VECTORED && kind_q == IRQ) ? BASE + {26'd0, cause_q, 2'b00} : BASE;
   end
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q       <= IDLE;
         kind_q        <= EXC;
         cause_q       <= '0;
         pc_q          <= '0;
         flush_q       <= 1'b0;
         stall_q       <= 1'b0;
         raised_q      <= 1'b0;
         intr_q        <= 1'b0;
         redir_valid_q <= 1'b0;
         ecause_q      <= '0;
         epc_q         <= '0;
         redir_q       <= '0;
         mie_q         <= 1'b0;
         mpie_q        <= 1'b0;
      end else begin
         raised_q      <= 1'b0;
         redir_valid_q <= 1'b0;
         case (state_q)
            IDLE: if (req) begin
               state_q <= FLUSH;
               kind_q  <= kind_d;
               cause_q <= cause_d;
               pc_q    <= pc_d;
               flush_q <= 1'b1;
               stall_q <= 1'b1;
            end
            FLUSH: if (bus.i_FlushAck) begin
               state_q       <= COMMIT;
               flush_q       <= 1'b0;
               redir_valid_q <= 1'b1;
               raised_q      <= kind_q != RET;
               if (kind_q != RET) begin
                  intr_q   <= kind_q == IRQ;
                  ecause_q <= cause_q;
                  epc_q    <= pc_q;
                  redir_q  <= target;
               end
            end
            COMMIT: begin
               state_q <= IDLE;
               stall_q <= 1'b0;
               // trap entry stacks MIE into MPIE; MRET restores it and sets MPIE
               mie_q   <= (kind_q == RET) & mpie_q;
               mpie_q  <= (kind_q == RET) | mie_q;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.o_FlushReq                    = flush_q;
   assign bus.o_Stall                       = stall_q;
   assign bus.o_ExceptionRaised             = raised_q;
   assign bus.o_Interrupt                   = intr_q;
   assign bus.o_ExceptionCause              = ecause_q;
   assign bus.o_ExceptionInstructionPointer = epc_q;
   assign bus.o_RedirectValid               = redir_valid_q;
   assign bus.o_RedirectPc                  = (state_q == COMMIT && kind_q == RET) ? bus.i_Mepc : redir_q;
   assign bus.o_Mie                         = mie_q;
   assign bus.o_Mpie                        = mpie_q;
endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: directed traps and returns with a queue-based scoreboard checked at each redirect
module tb_trap_controller;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int tests = 0;
   int fails = 0;
   int flush_spans = 0;
   int raised_cnt = 0;
   int cnt;
   logic prev_flush = 1'b0;
   logic chk_mie = 1'b0;
   typedef struct {
      logic        trap;
      logic        intr;
      logic [3:0]  cause;
      logic [31:0] epc;
      logic [31:0] rpc;
      logic        mie;
      logic        mpie;
   } exp_t;
   exp_t q[$];
   exp_t cur;
   trap_controller_if bus();
   trap_controller #(.MTVEC_BASE(32'h0000_0100), .VECTORED(1'b1)) dut (
      .i_Clock  (clk),
      .i_Reset_n(rst_n),
      .bus      (bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic expect_(input logic trap, input logic intr, input logic [3:0] cause, input logic [31:0] epc,
                          input logic [31:0] rpc, input logic mie, input logic mpie);
      exp_t e;
      e.trap = trap; e.intr = intr; e.cause = cause; e.epc = epc; e.rpc = rpc; e.mie = mie; e.mpie = mpie;
      q.push_back(e);
   endtask
   // wait for flush, drop one-shot requests, ack after dly cycles, wait for stall release
   task automatic serve(input int dly, input logic [2:0] pend_flush);
      int n = 0;
      while (!bus.o_FlushReq && n < 50) begin @(negedge clk); n++; end
      chk("flush_seen", bus.o_FlushReq, 1);
      bus.i_ExcValid = 1'b0;
      bus.i_Mret = 1'b0;
      bus.i_IrqPending = pend_flush;
      repeat (dly) @(negedge clk);
      bus.i_FlushAck = 1'b1;
      @(negedge clk);
      bus.i_FlushAck = 1'b0;
      n = 0;
      while (bus.o_Stall && n < 50) begin @(negedge clk); n++; end
      chk("stall_released", bus.o_Stall, 0);
   endtask
   always @(negedge clk) begin
      if (!rst_n) begin
         chk_mie = 1'b0;
         prev_flush = 1'b0;
      end else begin
         if (bus.o_FlushReq && !prev_flush) flush_spans++;
         prev_flush = bus.o_FlushReq;
         if (bus.o_ExceptionRaised) raised_cnt++;
         if (chk_mie) begin
            chk("mie_after", bus.o_Mie, cur.mie);
            chk("mpie_after", bus.o_Mpie, cur.mpie);
            chk_mie = 1'b0;
         end
         if (bus.o_RedirectValid) begin
            if (q.size() == 0) chk("unexpected_redirect", 1, 0);
            else begin
               cur = q.pop_front();
               chk("raised", bus.o_ExceptionRaised, cur.trap);
               chk("redirect_pc", bus.o_RedirectPc, cur.rpc);
               chk("commit_stall", bus.o_Stall, 1);
               chk("commit_flushreq", bus.o_FlushReq, 0);
               if (cur.trap) begin
                  chk("interrupt", bus.o_Interrupt, cur.intr);
                  chk("cause", bus.o_ExceptionCause, cur.cause);
                  chk("epc", bus.o_ExceptionInstructionPointer, cur.epc);
               end
               chk_mie = 1'b1;
            end
         end else if (bus.o_ExceptionRaised) chk("raised_without_redirect", 1, 0);
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.i_ExcValid = 1'b0;
      bus.i_ExcCause = '0;
      bus.i_ExcPc = '0;
      bus.i_Mret = 1'b0;
      bus.i_NextPc = '0;
      bus.i_IrqPending = '0;
      bus.i_IrqEnable = '0;
      bus.i_Mepc = '0;
      bus.i_FlushAck = 1'b0;
      #1 rst_n = 1'b0;
      #11;
      chk("rst_flushreq", bus.o_FlushReq, 0);
      chk("rst_stall", bus.o_Stall, 0);
      chk("rst_raised", bus.o_ExceptionRaised, 0);
      chk("rst_redirect_valid", bus.o_RedirectValid, 0);
      chk("rst_redirect_pc", bus.o_RedirectPc, 0);
      chk("rst_mie", bus.o_Mie, 0);
      chk("rst_mpie", bus.o_Mpie, 0);
      @(negedge clk);
      rst_n = 1'b1;
      // interrupts pending and enabled, but MIE is 0 out of reset
      bus.i_IrqPending = 3'b111;
      bus.i_IrqEnable = 3'b111;
      cnt = 0;
      repeat (20) begin @(negedge clk); if (bus.o_Stall || bus.o_FlushReq) cnt++; end
      chk("mask_busy_cycles", cnt, 0);
      bus.i_IrqPending = 3'b000;
      flush_spans = 0;
      raised_cnt = 0;
      expect_(1, 0, 4'd2, 32'h40, 32'h100, 0, 0);
      bus.i_ExcValid = 1'b1; bus.i_ExcCause = 4'd2; bus.i_ExcPc = 32'h40;
      serve(2, 3'b000);
      @(negedge clk);
      chk("exc_flush_spans", flush_spans, 1);
      chk("exc_raised_pulses", raised_cnt, 1);
      expect_(0, 0, 4'd0, 32'h0, 32'h1000, 0, 1);
      bus.i_Mepc = 32'h1000; bus.i_Mret = 1'b1;
      serve(1, 3'b000);
      raised_cnt = 0;
      expect_(0, 0, 4'd0, 32'h0, 32'h2000, 1, 1);
      bus.i_Mepc = 32'h2000; bus.i_Mret = 1'b1;
      serve(1, 3'b000);
      @(negedge clk);
      chk("mret_no_raise", raised_cnt, 0);
      // vectored timer interrupt; pending changes mid-flush must not alter cause
      expect_(1, 1, 4'd7, 32'h80, 32'h11C, 0, 1);
      bus.i_IrqEnable = 3'b001; bus.i_IrqPending = 3'b001; bus.i_NextPc = 32'h80;
      serve(2, 3'b100);
      bus.i_IrqPending = 3'b000;
      bus.i_IrqEnable = 3'b111;
      expect_(0, 0, 4'd0, 32'h0, 32'h3000, 1, 1);
      bus.i_Mepc = 32'h3000; bus.i_Mret = 1'b1;
      serve(1, 3'b000);
      expect_(1, 0, 4'd4, 32'h44, 32'h100, 0, 1);
      bus.i_ExcValid = 1'b1; bus.i_ExcCause = 4'd4; bus.i_ExcPc = 32'h44;
      bus.i_IrqPending = 3'b111; bus.i_NextPc = 32'h90; bus.i_Mret = 1'b1;
      serve(1, 3'b111);
      expect_(0, 0, 4'd0, 32'h0, 32'h4000, 1, 1);
      expect_(1, 1, 4'd11, 32'h90, 32'h12C, 0, 1);
      bus.i_Mepc = 32'h4000; bus.i_Mret = 1'b1;
      serve(1, 3'b111);
      serve(1, 3'b011);
      expect_(0, 0, 4'd0, 32'h0, 32'h5000, 1, 1);
      expect_(1, 1, 4'd3, 32'h90, 32'h10C, 0, 1);
      bus.i_Mepc = 32'h5000; bus.i_Mret = 1'b1;
      serve(1, 3'b011);
      serve(1, 3'b000);
      @(negedge clk);
      // asynchronous reset while waiting in FLUSH
      bus.i_ExcValid = 1'b1; bus.i_ExcCause = 4'd5; bus.i_ExcPc = 32'h60;
      cnt = 0;
      while (!bus.o_FlushReq && cnt < 10) begin @(negedge clk); cnt++; end
      chk("rstflush_seen", bus.o_FlushReq, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_flushreq", bus.o_FlushReq, 0);
      chk("arst_stall", bus.o_Stall, 0);
      chk("arst_mpie", bus.o_Mpie, 0);
      chk("arst_cause", bus.o_ExceptionCause, 0);
      chk("arst_epc", bus.o_ExceptionInstructionPointer, 0);
      chk("arst_redirect_pc", bus.o_RedirectPc, 0);
      bus.i_ExcValid = 1'b0;
      @(negedge clk);
      bus.i_FlushAck = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bus.i_FlushAck = 1'b0;
      cnt = 0;
      repeat (10) begin @(negedge clk); if (bus.o_Stall || bus.o_RedirectValid || bus.o_FlushReq) cnt++; end
      chk("post_reset_activity", cnt, 0);
      chk("scoreboard_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
